// File: rtl/gpr_file_mp.sv
// Parametrised multi-port GPR file with write-to-read bypass and a per-register
// busy scoreboard. Storage has no reset; a post-reset sequencer zeroes it entry by entry.
module gpr_file_mp #(
  parameter  int XLEN   = 64,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic [AW-1:0]       waddr_i,
  input  logic [XLEN-1:0]     wdata_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  input  logic                bset_i,
  input  logic [AW-1:0]       bset_addr_i,
  output logic                ready_o
);

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic [NREG-1:0]   busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREG];

  logic run_s;
  logic wr_en_s;
  logic bset_en_s;

  assign run_s     = (state_q == ST_RUN);
  assign wr_en_s   = run_s && we_i && (waddr_i != '0);
  assign bset_en_s = run_s && bset_i && (bset_addr_i != '0);
  assign ready_o   = run_s;

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == AW'(NREG - 1)) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Set after clear so a writeback and a new issue to the same register leave it busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_s) begin
      busy_d[waddr_i] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (bset_en_s) begin
      busy_d[bset_addr_i] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= AW'(1);
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      busy_q    <= busy_d;
    end
  end

  // Storage is not reset; it is held while rst is high and zeroed during CLEAR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run_s) begin
        regs_q[clr_ptr_q] <= '0;
      end else if (wr_en_s) begin
        regs_q[waddr_i] <= wdata_i;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   ra_s;
    logic [XLEN-1:0] rd_s;
    logic            rb_s;

    assign ra_s = raddr_i[k*AW +: AW];

    always_comb begin
      rd_s = '0;
      rb_s = 1'b0;
      if (run_s && (ra_s != '0)) begin
        if ((BYPASS != 0) && we_i && (ra_s == waddr_i)) begin
          rd_s = wdata_i;
          rb_s = 1'b0;
        end else begin
          rd_s = regs_q[ra_s];
          rb_s = busy_q[ra_s];
        end
      end else begin
        rd_s = '0;
        rb_s = 1'b0;
      end
    end

    assign rdata_o[k*XLEN +: XLEN] = rd_s;
    assign rbusy_o[k]              = rb_s;
  end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Bench for gpr_file_mp: a bypassing and a non-bypassing 4-port instance share
// inputs and are compared against a behavioural register/scoreboard model.
module tb_gpr_file_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 4;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                we = 1'b0;
  logic [AW-1:0]       waddr = '0;
  logic [XLEN-1:0]     wdata = '0;
  logic [AW-1:0]       ra [NRD];
  logic [NRD*AW-1:0]   raddr_v;
  logic                bset = 1'b0;
  logic [AW-1:0]       baddr = '0;
  logic [NRD*XLEN-1:0] rdata_b, rdata_n;
  logic [NRD-1:0]      rbusy_b, rbusy_n;
  logic                ready_b, ready_n;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: architectural contents, busy set and clear-progress edge count.
  logic [XLEN-1:0] m_regs [NREG];
  bit              m_busy [NREG];
  bit              m_run = 1'b0;
  int              m_cnt = 0;

  assign raddr_v = {ra[3], ra[2], ra[1], ra[0]};

  always #5 clk = ~clk;

  gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr_v), .rdata_o(rdata_b), .rbusy_o(rbusy_b),
    .bset_i(bset), .bset_addr_i(baddr), .ready_o(ready_b));

  gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) u_nobyp (
    .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr_v), .rdata_o(rdata_n), .rbusy_o(rbusy_n),
    .bset_i(bset), .bset_addr_i(baddr), .ready_o(ready_n));

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (!m_run || a == 0) return '0;
    if (byp && we && a == waddr) return wdata;
    return m_regs[a];
  endfunction

  function automatic logic exp_rb(input logic [AW-1:0] a, input bit byp);
    if (!m_run || a == 0) return 1'b0;
    if (byp && we && a == waddr) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check_all();
    chk("ready_byp", 64'(ready_b), 64'(m_run));
    chk("ready_nobyp", 64'(ready_n), 64'(m_run));
    for (int k = 0; k < NRD; k++) begin
      chk($sformatf("rdata_byp[%0d] a=%0d", k, ra[k]), rdata_b[k*XLEN +: XLEN], exp_rd(ra[k], 1'b1));
      chk($sformatf("rdata_nobyp[%0d] a=%0d", k, ra[k]), rdata_n[k*XLEN +: XLEN], exp_rd(ra[k], 1'b0));
      chk($sformatf("rbusy_byp[%0d] a=%0d", k, ra[k]), 64'(rbusy_b[k]), 64'(exp_rb(ra[k], 1'b1)));
      chk($sformatf("rbusy_nobyp[%0d] a=%0d", k, ra[k]), 64'(rbusy_n[k]), 64'(exp_rb(ra[k], 1'b0)));
    end
  endtask

  task automatic model_edge();
    if (rst) return;
    if (!m_run) begin
      m_cnt++;
      if (m_cnt == NREG - 1) begin
        m_run = 1'b1;
        for (int i = 0; i < NREG; i++) m_regs[i] = '0;
      end
    end else begin
      if (we && waddr != 0) begin
        m_regs[waddr] = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (bset && baddr != 0) m_busy[baddr] = 1'b1;
    end
  endtask

  // Check outputs mid-low-phase, then advance one clock edge and update the model.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    m_run = 1'b0;
    m_cnt = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_in();
    we = 1'b0; bset = 1'b0; waddr = '0; baddr = '0; wdata = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
    ra[0] = AW'(a0); ra[1] = AW'(a1); ra[2] = AW'(a2); ra[3] = AW'(a3);
  endtask

  initial begin
    idle_in();
    set_rd(0, 1, 2, 3);
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    pulse_reset();

    // Clear sequence: ready_o must rise after exactly NREG-1 edges.
    for (int i = 0; i < NREG - 1; i++) cycle();
    chk("ready_after_clear", 64'(ready_b), 64'(1));
    for (int a = 0; a < NREG; a += 4) begin
      set_rd(a, a + 1, a + 2, a + 3);
      cycle();
    end

    // Same-cycle write/read of x5, then read back.
    we = 1'b1; waddr = 5'd5; wdata = 64'hDEADBEEF_0000_0001;
    set_rd(5, 5, 0, 6);
    cycle();
    idle_in();
    cycle();

    // Writes to x0 are dropped; bset on x0 is ignored.
    we = 1'b1; waddr = 5'd0; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
    bset = 1'b1; baddr = 5'd0;
    set_rd(0, 0, 5, 0);
    cycle();
    idle_in();
    cycle();

    // Scoreboard: set, set+writeback same cycle, writeback alone.
    bset = 1'b1; baddr = 5'd7;
    set_rd(7, 7, 5, 8);
    cycle();
    we = 1'b1; waddr = 5'd7; wdata = 64'h0000_0000_0000_0777;
    cycle();
    idle_in();
    cycle();
    we = 1'b1; waddr = 5'd7; wdata = 64'h1234_5678_9ABC_DEF0;
    cycle();
    idle_in();
    cycle();

    // Reset in the middle of CLEAR (clr_ptr == 10).
    pulse_reset();
    for (int i = 0; i < 9; i++) cycle();
    pulse_reset();
    for (int i = 0; i < NREG - 1; i++) cycle();
    chk("ready_after_midclear_reset", 64'(ready_n), 64'(1));

    // Reset in RUN with busy bits and data present.
    for (int i = 1; i <= 4; i++) begin
      bset = 1'b1; baddr = AW'(i);
      we = 1'b1; waddr = AW'(i + 10); wdata = {32'(i), $urandom()};
      set_rd(i, i + 10, 1, 2);
      cycle();
    end
    idle_in();
    set_rd(1, 2, 3, 4);
    cycle();
    pulse_reset();
    for (int i = 0; i < NREG - 1; i++) cycle();
    set_rd(1, 2, 11, 14);
    cycle();

    // Distinct ports, then duplicate addresses.
    for (int i = 1; i <= 4; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = {$urandom(), $urandom()};
      cycle();
    end
    idle_in();
    set_rd(1, 2, 3, 4);
    cycle();
    set_rd(3, 3, 1, 3);
    cycle();

    // Random mix biased toward a few registers to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      we    = 1'($urandom_range(0, 1));
      waddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
      wdata = {$urandom(), $urandom()};
      bset  = 1'($urandom_range(0, 1));
      baddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREG - 1));
      for (int k = 0; k < NRD; k++) begin
        case ($urandom_range(0, 3))
          0:       ra[k] = waddr;
          1:       ra[k] = ra[0];
          2:       ra[k] = AW'($urandom_range(0, 7));
          default: ra[k] = AW'($urandom_range(0, NREG - 1));
        endcase
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
